// File: rtl/iic_slave_rx.sv
// Write-only I2C target. Oversamples SCL/SDA, decodes START/STOP, ACKs bytes
// addressed to CHIP_ADDR, and turns each data byte into a register-write strobe.
module iic_slave_rx #(
  parameter logic [6:0] CHIP_ADDR   = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       nack_evt
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic [7:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   nack_q, nack_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic byte_state, addr_match;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    byte_state = (state_q == ADDR) || (state_q == REG) || (state_q == DATA);
    addr_match = (shift_q[7:1] == CHIP_ADDR) && !shift_q[0];
  end

  // Line events take priority; otherwise bits shift in on SCL rise and each
  // completed byte is acted upon at the following SCL fall, when SDA may change.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    nack_d    = 1'b0;

    if (start_det) begin
      state_d  = ADDR;
      shift_d  = 8'h00;
      cnt_d    = 3'd0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (byte_state && scl_rise && !full_q) begin
      shift_d = {shift_q[6:0], sda_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        full_d = 1'b1;
      end
    end else if (byte_state && scl_fall && full_q) begin
      full_d   = 1'b0;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b1;
      unique case (state_q)
        ADDR: begin
          if (addr_match) begin
            state_d = ADDR_ACK;
            busy_d  = 1'b1;
          end else begin
            state_d  = IGNORE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            nack_d   = 1'b1;
          end
        end
        REG: begin
          wr_addr_d = shift_q;
          state_d   = REG_ACK;
        end
        default: begin
          wr_data_d = shift_q;
          wr_en_d   = 1'b1;
          state_d   = DATA_ACK;
        end
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = REG;
        end
        REG_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = DATA;
        end
        DATA_ACK: begin
          sda_oe_d  = 1'b0;
          wr_addr_d = wr_addr_q + 8'd1;
          state_d   = DATA;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      full_q     <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign nack_evt = nack_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// Directed bench for iic_slave_rx: a bit-banged I2C master drives the bus and
// a monitor scores every wr_en against a queue of expected register writes.
module tb_iic_slave_rx;

  localparam int SYNC = 2;
  localparam int Q    = 4;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl_pad;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       nack_evt;

  int      checks    = 0;
  int      fails     = 0;
  int      cyc       = 0;
  int      nack_seen = 0;
  int      nack_base;
  wr_exp_t wr_q[$];
  wr_exp_t mon_e;

  assign sda_in = sda_m & ~sda_oe;

  iic_slave_rx #(.CHIP_ADDR(7'h50), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .scl_in   (scl_pad),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .nack_evt (nack_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic scl_v, input logic sda_v, input int n);
    scl_pad = scl_v;
    sda_m   = sda_v;
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    applyStimulus(scl_pad, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2c_stop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, Q);
  endtask

  // Clocks out the top n bits of b; a write is expected right after the 8th fall.
  task automatic send_bits(input logic [7:0] b, input int n, input logic exp_wr,
                           input logic [7:0] exp_addr);
    wr_exp_t e;
    for (int i = 7; i > 7 - n; i--) begin
      applyStimulus(1'b0, b[i], Q);
      applyStimulus(1'b1, b[i], 2 * Q);
      if (i == 0 && exp_wr) begin
        e.addr = exp_addr;
        e.data = b;
        e.cyc  = cyc + SYNC + 1;
        wr_q.push_back(e);
      end
      applyStimulus(1'b0, b[i], Q);
    end
  endtask

  task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack,
                           input logic exp_wr, input logic [7:0] exp_addr);
    send_bits(b, 8, exp_wr, exp_addr);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    checkOutput(name, {31'd0, ~sda_in}, {31'd0, exp_ack});
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        checkOutput("wr_en_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = wr_q.pop_front();
        checkOutput("wr_addr", {24'd0, wr_addr}, {24'd0, mon_e.addr});
        checkOutput("wr_data", {24'd0, wr_data}, {24'd0, mon_e.data});
        checkOutput("wr_latency", cyc, mon_e.cyc);
      end
    end
    if (nack_evt) nack_seen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn    = 1'b0;
    scl_pad = 1'b1;
    sda_m   = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", {24'd0, wr_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_nack", {31'd0, nack_evt}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single write 0x50/W reg 0x12 data 0xA5");
    i2c_start();
    send_byte("t1_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    checkOutput("t1_busy_on", {31'd0, busy}, 32'd1);
    send_byte("t1_reg_ack", 8'h12, 1'b1, 1'b0, 8'h00);
    send_byte("t1_data_ack", 8'hA5, 1'b1, 1'b1, 8'h12);
    i2c_stop();
    checkOutput("t1_busy_off", {31'd0, busy}, 32'd0);
    checkOutput("t1_sda_oe", {31'd0, sda_oe}, 32'd0);

    $display("[TB] wrong address 0x51/W, then a good write");
    nack_base = nack_seen;
    i2c_start();
    send_byte("t2_addr_nack", 8'hA2, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_busy", {31'd0, busy}, 32'd0);
    send_byte("t2_ignored", 8'h12, 1'b0, 1'b0, 8'h00);
    i2c_stop();
    checkOutput("t2_nack_pulses", nack_seen - nack_base, 32'd1);
    i2c_start();
    send_byte("t2_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_byte("t2_reg_ack", 8'h34, 1'b1, 1'b0, 8'h00);
    send_byte("t2_data_ack", 8'h56, 1'b1, 1'b1, 8'h34);
    i2c_stop();

    $display("[TB] burst across register address wrap");
    i2c_start();
    send_byte("t3_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_byte("t3_reg_ack", 8'hFE, 1'b1, 1'b0, 8'h00);
    send_byte("t3_d0_ack", 8'h11, 1'b1, 1'b1, 8'hFE);
    send_byte("t3_d1_ack", 8'h22, 1'b1, 1'b1, 8'hFF);
    send_byte("t3_d2_ack", 8'h33, 1'b1, 1'b1, 8'h00);
    i2c_stop();

    $display("[TB] repeated start after a partial data byte");
    i2c_start();
    send_byte("t4_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_byte("t4_reg_ack", 8'h20, 1'b1, 1'b0, 8'h00);
    send_bits(8'hB0, 4, 1'b0, 8'h00);
    i2c_start();
    checkOutput("t4_sda_oe_rs", {31'd0, sda_oe}, 32'd0);
    send_byte("t4_addr2_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_byte("t4_reg2_ack", 8'h03, 1'b1, 1'b0, 8'h00);
    send_byte("t4_data_ack", 8'h7E, 1'b1, 1'b1, 8'h03);
    i2c_stop();

    $display("[TB] stop in the middle of the register byte");
    i2c_start();
    send_byte("t5_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_bits(8'h5C, 4, 1'b0, 8'h00);
    i2c_stop();
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_sda_oe", {31'd0, sda_oe}, 32'd0);

    $display("[TB] reset while acknowledging a data byte");
    i2c_start();
    send_byte("t5r_addr_ack", 8'hA0, 1'b1, 1'b0, 8'h00);
    send_byte("t5r_reg_ack", 8'h40, 1'b1, 1'b0, 8'h00);
    send_bits(8'h99, 8, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b1, Q);
    checkOutput("t5r_sda_oe_ack", {31'd0, sda_oe}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("t5r_sda_oe_rst", {31'd0, sda_oe}, 32'd0);
    checkOutput("t5r_busy_rst", {31'd0, busy}, 32'd0);
    checkOutput("t5r_wr_addr_rst", {24'd0, wr_addr}, 32'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b1, Q);
    i2c_stop();
    checkOutput("t5r_busy_after", {31'd0, busy}, 32'd0);

    $display("[TB] read request 0x50/R is refused");
    nack_base = nack_seen;
    i2c_start();
    send_byte("t6_addr_nack", 8'hA1, 1'b0, 1'b0, 8'h00);
    send_byte("t6_ignored", 8'h55, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    checkOutput("t6_nack_pulses", nack_seen - nack_base, 32'd1);

    repeat (20) @(negedge clk);
    checkOutput("writes_pending", wr_q.size(), 32'd0);
    checkOutput("nack_total", nack_seen, 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
